// File: rtl/serial_to_parallel_rx.sv
// Serial receiver: hunts for IDLE_SYM bit alignment, locks after SYNC_COUNT
// consecutive aligned idles, then re-assembles bytes with a valid strobe.
module serial_to_parallel_rx #(
  parameter logic [7:0] IDLE_SYM   = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       IDL
);

  typedef enum logic [1:0] {SEARCH, COUNT, LOCKED} state_t;

  localparam logic [3:0] SYNC_N = 4'(SYNC_COUNT);

  state_t     state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic       idle_hit;
  logic       boundary;

  assign idle_hit = (sr == IDLE_SYM);
  assign boundary = (bit_cnt == 3'd0);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      bc_cnt    <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
      IDL       <= 1'b0;
    end else begin
      sr        <= {sr[6:0], data_in};
      valid_out <= 1'b0;
      case (state)
        // Alignment is checked on every bit until an idle shows up.
        SEARCH: begin
          if (idle_hit) begin
            bit_cnt <= 3'd1;
            bc_cnt  <= 4'd1;
            if (SYNC_N == 4'd1) begin
              state  <= LOCKED;
              active <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (idle_hit) begin
              bc_cnt <= bc_cnt + 4'd1;
              if (bc_cnt + 4'd1 == SYNC_N) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              state  <= SEARCH;
              bc_cnt <= 4'd0;
            end
          end
        end
        // No loss-of-lock detection: only reset leaves this state.
        LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (idle_hit) begin
              IDL <= 1'b1;
            end else begin
              IDL       <= 1'b0;
              data_out  <= sr;
              valid_out <= 1'b1;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: directed scenarios plus random streams,
// every cycle compared against a bit-history reference model.
module tb_serial_to_parallel_rx;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         SYNC = 4;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       IDL;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  serial_to_parallel_rx #(.IDLE_SYM(IDLE), .SYNC_COUNT(SYNC)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .IDL      (IDL)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  // Reference model: bits received since reset, plus the absolute bit index
  // of the last byte end the receiver aligned to.
  bit         hist[$];
  int         m_mode;     // 0 hunting, 1 counting idles, 2 locked
  int         m_anchor;
  int         m_run;
  logic [7:0] m_data;
  logic       m_vld;
  logic       m_idl;
  logic       m_act;

  function automatic logic [7:0] last_byte();
    logic [7:0] w;
    int idx;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = hist.size() - 8 + i;
      w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_edge(input logic b, input logic r);
    logic [7:0] w;
    int n;
    if (r) begin
      hist.delete();
      m_mode = 0; m_anchor = 0; m_run = 0;
      m_data = 8'h00; m_vld = 1'b0; m_idl = 1'b0; m_act = 1'b0;
      return;
    end
    w = last_byte();
    n = hist.size();
    m_vld = 1'b0;
    if (m_mode == 0) begin
      if (w == IDLE) begin
        m_anchor = n;
        m_run = 1;
        if (SYNC == 1) begin m_mode = 2; m_act = 1'b1; end
        else m_mode = 1;
      end
    end else if ((n - m_anchor) % 8 == 0) begin
      if (m_mode == 1) begin
        if (w == IDLE) begin
          m_run++;
          if (m_run == SYNC) begin m_mode = 2; m_act = 1'b1; end
        end else begin
          m_mode = 0; m_run = 0;
        end
      end else if (w == IDLE) begin
        m_idl = 1'b1;
      end else begin
        m_idl = 1'b0; m_data = w; m_vld = 1'b1;
      end
    end
    hist.push_back(b);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_data_out", data_out, m_data);
    chk("model_valid_out", {7'b0, valid_out}, {7'b0, m_vld});
    chk("model_active", {7'b0, active}, {7'b0, m_act});
    chk("model_IDL", {7'b0, IDL}, {7'b0, m_idl});
  endtask

  task automatic step(input logic b, input logic r);
    reset = r;
    data_in = b;
    @(posedge clk_32f);
    model_edge(b, r);
    #1;
    check_model();
  endtask

  task automatic send_bits(input logic [7:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) step(v[i], 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 7, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, data_out, 8'h00);
    chk({tag, "_vld"}, {7'b0, valid_out}, 8'h00);
    chk({tag, "_act"}, {7'b0, active}, 8'h00);
    chk({tag, "_idl"}, {7'b0, IDL}, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    data_in = 1'b0;

    // Reset with arbitrary bits, then release on zeros.
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1);
    chk_all_zero("reset");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk_all_zero("post_release");

    // Four aligned idles lock on the next edge; IDL follows the fifth.
    for (int i = 0; i < 4; i++) send_byte(IDLE);
    chk("lock_pre", {7'b0, active}, 8'h00);
    step(IDLE[7], 1'b0);
    chk("lock_rise", {7'b0, active}, 8'h01);
    send_bits(IDLE, 6, 0);
    chk("idl_pre", {7'b0, IDL}, 8'h00);
    step(IDLE[7], 1'b0);
    chk("idl_rise", {7'b0, IDL}, 8'h01);
    send_bits(IDLE, 6, 0);

    // Bit offset before the idles, then two data bytes.
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(IDLE);
    send_byte(8'hA5);
    chk("a5_no_early_vld", {7'b0, valid_out}, 8'h00);
    step(1'b0, 1'b0);
    chk("a5_vld", {7'b0, valid_out}, 8'h01);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_idl_drop", {7'b0, IDL}, 8'h00);
    chk("a5_active", {7'b0, active}, 8'h01);
    send_bits(8'h3C, 6, 0);
    step(IDLE[7], 1'b0);
    chk("3c_vld", {7'b0, valid_out}, 8'h01);
    chk("3c_data", data_out, 8'h3C);
    send_bits(IDLE, 6, 0);

    // A non-idle byte during counting restarts the hunt.
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    send_byte(8'h17);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    step(IDLE[7], 1'b0);
    chk("restart_no_lock", {7'b0, active}, 8'h00);
    send_bits(IDLE, 6, 0);
    step(8'h01 >> 7, 1'b0);
    chk("restart_lock", {7'b0, active}, 8'h01);
    send_bits(8'h01, 6, 0);

    // Data, idle, data while locked.
    step(IDLE[7], 1'b0);
    chk("d01_vld", {7'b0, valid_out}, 8'h01);
    chk("d01_data", data_out, 8'h01);
    send_bits(IDLE, 6, 0);
    step(1'b1, 1'b0);
    chk("idle_hold_vld", {7'b0, valid_out}, 8'h00);
    chk("idle_hold_data", data_out, 8'h01);
    chk("idle_hold_idl", {7'b0, IDL}, 8'h01);
    send_bits(8'hFF, 6, 0);
    step(1'b0, 1'b0);
    chk("dff_data", data_out, 8'hFF);

    // Reset mid-byte while locked; relock needs four fresh idles.
    send_bits(8'h00, 6, 4);
    step(1'b1, 1'b1);
    chk_all_zero("mid_reset");
    for (int i = 0; i < 4; i++) send_byte(IDLE);
    chk("relock_pre", {7'b0, active}, 8'h00);
    step(1'b0, 1'b0);
    chk("relock", {7'b0, active}, 8'h01);

    // Random bit soup while hunting.
    step(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // Random offset, lock, then random bytes mixed with idles.
    step(1'b0, 1'b1);
    for (int i = 0; i < int'($urandom_range(0, 7)); i++) step(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(IDLE);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) send_byte(IDLE);
      else send_byte(8'($urandom));
    end
    chk("rand_locked", {7'b0, active}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
Receive-side stage directly downstream of the parallel-to-serial transmitter. It consumes the serial bit stream on clk_32f, finds byte alignment by hunting for the IDLE symbol (8'hBC), and declares link active after SYNC_COUNT consecutive aligned IDLEs. Once locked, it re-assembles bytes, flags data bytes with a valid strobe and reports an idle indication, for use by the downstream byte-unstriping logic.

Parameters:
IDLE_SYM, 8'hBC, alignment/idle symbol; also the byte the transmitter sends while inactive.
SYNC_COUNT, 4, consecutive aligned IDLE bytes required to reach lock (legal 1..15).

Ports:
clk_32f  input  1  bit clock; the only clock; all flops on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  1  serial bit, MSB of each byte first, one bit per clk_32f.
data_out  output  8  last assembled non-idle byte; holds between updates.
valid_out  output  1  one-cycle pulse when data_out is loaded with a new data byte.
active  output  1  high while in LOCKED state.
IDL  output  1  high while the most recent aligned byte in LOCKED was IDLE_SYM.

Behaviour:
- Reset (reset=1 at a rising edge): sr=8'h00, bit_cnt=0, bc_cnt=0, state=SEARCH, data_out=8'h00, valid_out=0, active=0, IDL=0. Reset has priority over everything, including mid-byte and while LOCKED.
- Shift register: every edge sr <= {sr[6:0], data_in}, in all states.
- bit_cnt (3 bits): free-running 0..7 wrap once aligned; "byte boundary" = cycle where bit_cnt==0 in COUNT/LOCKED; at that cycle sr holds a complete aligned byte.
- SEARCH: evaluated every cycle. If sr==IDLE_SYM: bit_cnt<=1, bc_cnt<=1; if SYNC_COUNT==1 go LOCKED, else go COUNT. Else stay; bit_cnt unused.
- COUNT: bit_cnt increments each edge. At byte boundary: sr==IDLE_SYM -> bc_cnt+1; if new count == SYNC_COUNT go LOCKED (active<=1 at same edge). sr!=IDLE_SYM -> SEARCH, bc_cnt<=0. Not at boundary: no change.
- LOCKED: bit_cnt increments each edge. At byte boundary, at the following edge:
  sr==IDLE_SYM -> IDL<=1, valid_out<=0, data_out unchanged.
  sr!=IDLE_SYM -> IDL<=0, data_out<=sr, valid_out<=1.
  All other edges: valid_out<=0; IDL, data_out hold.
- Latency: last bit of a byte sampled at edge E; byte boundary visible after E; data_out/valid_out/IDL update at edge E+1.
- valid_out is never high for two consecutive cycles; minimum spacing 8 cycles.
- No loss-of-lock detection: once LOCKED, stays LOCKED until reset; a misaligned stream is passed through as data.
- A byte equal to IDLE_SYM straddling the boundary in COUNT/LOCKED is ignored (only aligned bytes are compared).
- The reset-time contents of sr must not produce a false IDLE match (sr=8'h00 guarantees this).

Test Plan:
1. Reset held 3 cycles while driving arbitrary bits -> all outputs 0, state SEARCH; release with data_in=0 -> outputs stay 0.
2. Aligned stream of 4x 8'hBC after reset -> active rises at edge immediately after the last bit of the 4th IDLE (32 bits sampled); IDL=1 one cycle after the next aligned IDLE.
3. 3 random bits, then 5x 8'hBC, then 8'hA5, 8'h3C -> bit-alignment found despite offset; active=1; data_out=8'hA5 with valid_out pulse one cycle after its last bit, then 8'h3C 8 cycles later; IDL drops to 0 with the 8'hA5 load.
4. 3x 8'hBC, 8'h17, 4x 8'hBC -> after 8'h17 returns to SEARCH (active stays 0); lock achieved only after the later 4 IDLEs.
5. Locked stream 8'h01, 8'hBC, 8'hFF -> valid_out pulses for 8'h01 and 8'hFF only; data_out holds 8'h01 during the IDLE byte while IDL=1.
6. Assert reset mid-byte while LOCKED with data_out=8'hFF -> next edge all outputs 0, active=0; relock requires 4 fresh aligned IDLEs.
